// File: rtl/multicycle_control_if.sv
// Memory port handshake between the multicycle control FSM
// and the unified instruction/data memory.
interface multicycle_control_if;
  logic mem_re;
  logic mem_we;
  logic i_or_d;
  logic mem_ready;

  modport master (
    output mem_re,
    output mem_we,
    output i_or_d,
    input  mem_ready
  );

  modport slave (
    input  mem_re,
    input  mem_we,
    input  i_or_d,
    output mem_ready
  );
endinterface

// File: rtl/multicycle_control.sv
// Control FSM for the multicycle MIPS-subset core: sequences the
// shared datapath, waits on memory and counts retired instructions.
module multicycle_control (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [5:0]  opcode,
  input  logic [5:0]  funct,
  input  logic        zero,
  multicycle_control_if.master mem,
  output logic        pc_we,
  output logic        ir_we,
  output logic        reg_we,
  output logic        reg_dst,
  output logic        mem_to_reg,
  output logic        alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [1:0]  alu_op,
  output logic [1:0]  pc_src,
  output logic        illegal,
  output logic        instr_done,
  output logic [3:0]  state,
  output logic [31:0] instr_count
);

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_EXEC_R    = 4'd6,
    S_R_WB      = 4'd7,
    S_BRANCH    = 4'd8,
    S_JUMP      = 4'd9,
    S_EXEC_I    = 4'd10,
    S_I_WB      = 4'd11,
    S_ILLEGAL   = 4'd12
  } state_e;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;

  state_e cur;
  state_e nxt;

  logic is_r;
  logic is_lw;
  logic is_sw;
  logic is_beq;
  logic is_j;
  logic is_addi;

  // funct is consumed by the ALU decoder, not here
  logic unused_funct;
  assign unused_funct = ^funct;

  assign is_r    = (opcode == OP_R);
  assign is_lw   = (opcode == OP_LW);
  assign is_sw   = (opcode == OP_SW);
  assign is_beq  = (opcode == OP_BEQ);
  assign is_j    = (opcode == OP_J);
  assign is_addi = (opcode == OP_ADDI);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur <= S_FETCH;
    end else begin
      cur <= nxt;
    end
  end

  always_comb begin
    nxt        = S_FETCH;
    pc_we      = 1'b0;
    ir_we      = 1'b0;
    mem.mem_re = 1'b0;
    mem.mem_we = 1'b0;
    mem.i_or_d = 1'b0;
    reg_we     = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    pc_src     = 2'b00;
    illegal    = 1'b0;
    instr_done = 1'b0;
    case (cur)
      S_FETCH: begin
        mem.mem_re = 1'b1;
        alu_src_b  = 2'b01;
        ir_we      = mem.mem_ready;
        pc_we      = mem.mem_ready;
        nxt        = mem.mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
        unique case (1'b1)
          is_r:          nxt = S_EXEC_R;
          is_lw, is_sw:  nxt = S_MEM_ADDR;
          is_beq:        nxt = S_BRANCH;
          is_j:          nxt = S_JUMP;
          is_addi:       nxt = S_EXEC_I;
          default:       nxt = S_ILLEGAL;
        endcase
      end
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        nxt       = is_lw ? S_MEM_READ : S_MEM_WRITE;
      end
      S_MEM_READ: begin
        mem.mem_re = 1'b1;
        mem.i_or_d = 1'b1;
        nxt        = mem.mem_ready ? S_MEM_WB : S_MEM_READ;
      end
      S_MEM_WB: begin
        reg_we     = 1'b1;
        mem_to_reg = 1'b1;
        instr_done = 1'b1;
      end
      S_MEM_WRITE: begin
        mem.mem_we = 1'b1;
        mem.i_or_d = 1'b1;
        instr_done = mem.mem_ready;
        nxt        = mem.mem_ready ? S_FETCH : S_MEM_WRITE;
      end
      S_EXEC_R: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
        nxt       = S_R_WB;
      end
      S_R_WB: begin
        reg_we     = 1'b1;
        reg_dst    = 1'b1;
        instr_done = 1'b1;
      end
      S_EXEC_I: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        nxt       = S_I_WB;
      end
      S_I_WB: begin
        reg_we     = 1'b1;
        instr_done = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a  = 1'b1;
        alu_op     = 2'b01;
        pc_src     = 2'b01;
        pc_we      = zero;
        instr_done = 1'b1;
      end
      S_JUMP: begin
        pc_src     = 2'b10;
        pc_we      = 1'b1;
        instr_done = 1'b1;
      end
      S_ILLEGAL: begin
        illegal = 1'b1;
      end
      default: nxt = S_FETCH;
    endcase
    // strobes must be quiet the moment reset asserts, not a cycle later
    if (!rst_n) begin
      pc_we      = 1'b0;
      ir_we      = 1'b0;
      mem.mem_re = 1'b0;
      mem.mem_we = 1'b0;
      reg_we     = 1'b0;
      illegal    = 1'b0;
      instr_done = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_count <= 32'd0;
    end else if (instr_done) begin
      instr_count <= instr_count + 32'd1;
    end
  end

  assign state = cur;

endmodule

// File: tb/tb_multicycle_control.sv
// Randomized bench for multicycle_control: instruction-level model
// expands each instruction into its expected per-cycle path.
module tb_multicycle_control;

  logic        clk;
  logic        rst_n;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic        zero;
  logic        pc_we;
  logic        ir_we;
  logic        reg_we;
  logic        reg_dst;
  logic        mem_to_reg;
  logic        alu_src_a;
  logic [1:0]  alu_src_b;
  logic [1:0]  alu_op;
  logic [1:0]  pc_src;
  logic        illegal;
  logic        instr_done;
  logic [3:0]  state;
  logic [31:0] instr_count;

  multicycle_control_if mif ();

  multicycle_control dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .opcode      (opcode),
    .funct       (funct),
    .zero        (zero),
    .mem         (mif),
    .pc_we       (pc_we),
    .ir_we       (ir_we),
    .reg_we      (reg_we),
    .reg_dst     (reg_dst),
    .mem_to_reg  (mem_to_reg),
    .alu_src_a   (alu_src_a),
    .alu_src_b   (alu_src_b),
    .alu_op      (alu_op),
    .pc_src      (pc_src),
    .illegal     (illegal),
    .instr_done  (instr_done),
    .state       (state),
    .instr_count (instr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {pc_we, ir_we, mem_re, mem_we, reg_we, illegal, instr_done}
  logic [6:0]  strb;
  // {i_or_d, reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_src}
  logic [10:0] sels;
  assign strb = {pc_we, ir_we, mif.mem_re, mif.mem_we,
                 reg_we, illegal, instr_done};
  assign sels = {mif.i_or_d, reg_dst, mem_to_reg, alu_src_a,
                 alu_src_b, alu_op, pc_src};

  typedef struct {
    int         st;
    logic [6:0] str;
    logic [10:0] sel;
    bit         rdy;
    bit         zr;
    logic [5:0] op;
  } step_t;

  step_t q[$];
  int    nchk;
  int    nerr;
  int    cnt;
  logic [5:0] cur_op;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)",
               tag, got, exp, $time);
    end
  endtask

  function automatic void add(int st, logic [6:0] str,
                              logic [10:0] sel, bit rdy, bit zr);
    step_t s;
    s.st  = st;
    s.str = str;
    s.sel = sel;
    s.rdy = rdy;
    s.zr  = zr;
    s.op  = cur_op;
    q.push_back(s);
  endfunction

  function automatic bit rnd();
    return bit'($urandom_range(0, 1));
  endfunction

  function automatic bit legal(logic [5:0] op);
    return op inside {6'b000000, 6'b100011, 6'b101011,
                      6'b000100, 6'b000010, 6'b001000};
  endfunction

  // kind: 0 R, 1 lw, 2 sw, 3 beq, 4 j, 5 addi, 6 illegal
  task automatic build(input int kind, input logic [5:0] bad,
                       input bit z, input int fs, input int ms);
    case (kind)
      0: cur_op = 6'b000000;
      1: cur_op = 6'b100011;
      2: cur_op = 6'b101011;
      3: cur_op = 6'b000100;
      4: cur_op = 6'b000010;
      5: cur_op = 6'b001000;
      default: cur_op = bad;
    endcase
    for (int i = 0; i < fs; i++)
      add(0, 7'b0010000, 11'b0_0_0_0_01_00_00, 1'b0, rnd());
    add(0, 7'b1110000, 11'b0_0_0_0_01_00_00, 1'b1, rnd());
    add(1, 7'b0000000, 11'b0_0_0_0_11_00_00, rnd(), rnd());
    case (kind)
      0: begin
        add(6, 7'b0000000, 11'b0_0_0_1_00_10_00, rnd(), rnd());
        add(7, 7'b0000101, 11'b0_1_0_0_00_00_00, rnd(), rnd());
      end
      1: begin
        add(2, 7'b0000000, 11'b0_0_0_1_10_00_00, rnd(), rnd());
        for (int i = 0; i < ms; i++)
          add(3, 7'b0010000, 11'b1_0_0_0_00_00_00, 1'b0, rnd());
        add(3, 7'b0010000, 11'b1_0_0_0_00_00_00, 1'b1, rnd());
        add(4, 7'b0000101, 11'b0_0_1_0_00_00_00, rnd(), rnd());
      end
      2: begin
        add(2, 7'b0000000, 11'b0_0_0_1_10_00_00, rnd(), rnd());
        for (int i = 0; i < ms; i++)
          add(5, 7'b0001000, 11'b1_0_0_0_00_00_00, 1'b0, rnd());
        add(5, 7'b0001001, 11'b1_0_0_0_00_00_00, 1'b1, rnd());
      end
      3: add(8, {z, 6'b000001}, 11'b0_0_0_1_00_01_01, rnd(), z);
      4: add(9, 7'b1000001, 11'b0_0_0_0_00_00_10, rnd(), rnd());
      5: begin
        add(10, 7'b0000000, 11'b0_0_0_1_10_00_00, rnd(), rnd());
        add(11, 7'b0000101, 11'b0_0_0_0_00_00_00, rnd(), rnd());
      end
      default:
        add(12, 7'b0000010, 11'b0_0_0_0_00_00_00, rnd(), rnd());
    endcase
  endtask

  task automatic run();
    step_t s;
    while (q.size() > 0) begin
      s = q.pop_front();
      @(negedge clk);
      opcode        = s.op;
      zero          = s.zr;
      mif.mem_ready = s.rdy;
      funct         = 6'($urandom);
      #1;
      chk("state", 32'(state), 32'(s.st));
      chk("strobes", 32'(strb), 32'(s.str));
      chk("selects", 32'(sels), 32'(s.sel));
      chk("count", instr_count, 32'(cnt));
      @(posedge clk);
      if (s.str[0]) cnt++;
    end
  endtask

  initial begin
    int         k;
    logic [5:0] bad;
    nchk          = 0;
    nerr          = 0;
    cnt           = 0;
    rst_n         = 1'b0;
    opcode        = 6'b000000;
    funct         = 6'b0;
    zero          = 1'b0;
    mif.mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_count", instr_count, 32'd0);
    chk("rst_strobes", 32'(strb), 32'd0);
    @(negedge clk);
    rst_n         = 1'b1;
    mif.mem_ready = 1'b0;

    build(0, 6'h00, 1'b0, 0, 0);
    build(1, 6'h00, 1'b0, 0, 2);
    build(3, 6'h00, 1'b1, 0, 0);
    build(3, 6'h00, 1'b0, 1, 0);
    build(2, 6'h00, 1'b0, 0, 0);
    build(4, 6'h00, 1'b0, 0, 0);
    build(6, 6'b111111, 1'b0, 0, 0);
    build(5, 6'h00, 1'b0, 0, 0);
    run();

    for (int n = 0; n < 60; n++) begin
      k = $urandom_range(0, 6);
      do bad = 6'($urandom); while (legal(bad));
      build(k, bad, rnd(), $urandom_range(0, 2), $urandom_range(0, 3));
      run();
    end

    // abort a lw while it waits in MEM_READ
    build(1, 6'h00, 1'b0, 0, 0);
    void'(q.pop_back());
    void'(q.pop_back());
    add(3, 7'b0010000, 11'b1_0_0_0_00_00_00, 1'b0, 1'b0);
    run();
    @(negedge clk);
    mif.mem_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    cnt = 0;
    chk("abort_state", 32'(state), 32'd0);
    chk("abort_count", instr_count, 32'd0);
    chk("abort_strobes", 32'(strb), 32'd0);
    @(posedge clk);
    #1;
    chk("hold_strobes", 32'(strb), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("resume_state", 32'(state), 32'd0);
    chk("resume_mem_re", 32'(mif.mem_re), 32'd1);
    chk("resume_i_or_d", 32'(mif.i_or_d), 32'd0);

    build(0, 6'h00, 1'b0, 0, 0);
    run();
    #1;
    chk("final_count", instr_count, 32'(cnt));

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
